// File: rtl/bch_bm_arb.sv
// Round-robin arbiter/sequencer sharing one Berlekamp-Massey block between two
// syndrome producers; zero syndromes bypass the BM block entirely.
module bch_bm_arb #(
  parameter int BM_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_valid,
  output logic       req0_ready,
  input  logic [3:0] req0_s1,
  input  logic [3:0] req0_s2,
  input  logic [3:0] req0_s3,
  input  logic       req1_valid,
  output logic       req1_ready,
  input  logic [3:0] req1_s1,
  input  logic [3:0] req1_s2,
  input  logic [3:0] req1_s3,
  output logic [3:0] bm_s1,
  output logic [3:0] bm_s2,
  output logic [3:0] bm_s3,
  input  logic [3:0] bm_lambda1,
  input  logic [3:0] bm_lambda2,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic       rsp_id,
  output logic [3:0] rsp_lambda1,
  output logic [3:0] rsp_lambda2,
  output logic [1:0] rsp_nerr,
  output logic       rsp_fail,
  output logic       busy,
  output logic [1:0] dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high. Request ready is combinational and only high in IDLE; a
  // response, once valid, holds its payload until rsp_ready is seen.

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_BYP, S_RESP} state_t;

  localparam logic [3:0] LP_LAT = 4'(BM_LAT);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_cnt;
  logic       r_last_grant;
  logic       r_id;
  logic [3:0] r_bm_s1, r_bm_s2, r_bm_s3;
  logic [3:0] r_lam1, r_lam2;
  logic [1:0] r_nerr;
  logic       r_fail;

  logic       w_idle, w_grant0, w_grant1, w_accept, w_zero, w_cap;
  logic [3:0] w_sel_s1, w_sel_s2, w_sel_s3;

  assign w_idle   = (r_state == S_IDLE);
  assign w_grant0 = req0_valid & (~req1_valid | r_last_grant);
  assign w_grant1 = req1_valid & (~req0_valid | ~r_last_grant);

  // Gated by rst so both readies read 0 while reset is held.
  assign req0_ready = rst & w_idle & w_grant0;
  assign req1_ready = rst & w_idle & w_grant1;
  assign w_accept   = req0_ready | req1_ready;

  assign w_sel_s1 = w_grant1 ? req1_s1 : req0_s1;
  assign w_sel_s2 = w_grant1 ? req1_s2 : req0_s2;
  assign w_sel_s3 = w_grant1 ? req1_s3 : req0_s3;
  assign w_zero   = ((w_sel_s1 | w_sel_s2 | w_sel_s3) == 4'd0);
  assign w_cap    = (r_state == S_RUN) && (r_cnt == LP_LAT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = w_zero ? S_BYP : S_RUN;
      S_RUN:  if (w_cap) w_next = S_RESP;
      S_BYP:  w_next = S_RESP;
      S_RESP: if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_last_grant <= 1'b1;
      r_id         <= 1'b0;
      r_bm_s1      <= 4'd0;
      r_bm_s2      <= 4'd0;
      r_bm_s3      <= 4'd0;
      r_lam1       <= 4'd0;
      r_lam2       <= 4'd0;
      r_nerr       <= 2'd0;
      r_fail       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_last_grant <= w_grant1;
        r_id         <= w_grant1;
        // Bypass jobs leave the BM inputs on the previous job's syndromes.
        if (!w_zero) begin
          r_bm_s1 <= w_sel_s1;
          r_bm_s2 <= w_sel_s2;
          r_bm_s3 <= w_sel_s3;
          r_cnt   <= 4'd1;
        end
      end else if ((r_state == S_RUN) && !w_cap) begin
        r_cnt <= r_cnt + 4'd1;
      end
      if (w_cap) begin
        r_lam1 <= bm_lambda1;
        r_lam2 <= bm_lambda2;
        r_nerr <= (bm_lambda2 != 4'd0) ? 2'd2 : ((bm_lambda1 != 4'd0) ? 2'd1 : 2'd0);
        // The RUN path only carries nonzero syndromes, so zero lambdas mean failure.
        r_fail <= (bm_lambda1 == 4'd0) && (bm_lambda2 == 4'd0);
      end else if (r_state == S_BYP) begin
        r_lam1 <= 4'd0;
        r_lam2 <= 4'd0;
        r_nerr <= 2'd0;
        r_fail <= 1'b0;
      end
    end
  end

  assign bm_s1       = r_bm_s1;
  assign bm_s2       = r_bm_s2;
  assign bm_s3       = r_bm_s3;
  assign rsp_valid   = (r_state == S_RESP);
  assign rsp_id      = r_id;
  assign rsp_lambda1 = r_lam1;
  assign rsp_lambda2 = r_lam2;
  assign rsp_nerr    = r_nerr;
  assign rsp_fail    = r_fail;
  assign busy        = (r_state != S_IDLE);
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_bch_bm_arb.sv
// Bench for bch_bm_arb: transaction-level model of job flow plus a GF(16)
// stand-in for the BM block, with directed scenarios and random traffic.
module tb_bch_bm_arb;

  localparam int BM_LAT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid, req0_ready, req1_ready;
  logic [3:0] req0_s1, req0_s2, req0_s3, req1_s1, req1_s2, req1_s3;
  logic [3:0] bm_s1, bm_s2, bm_s3, bm_lambda1, bm_lambda2;
  logic       rsp_valid, rsp_ready, rsp_id, rsp_fail, busy;
  logic [3:0] rsp_lambda1, rsp_lambda2;
  logic [1:0] rsp_nerr, dbg_state;

  bch_bm_arb #(.BM_LAT(BM_LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_s1(req0_s1), .req0_s2(req0_s2), .req0_s3(req0_s3),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_s1(req1_s1), .req1_s2(req1_s2), .req1_s3(req1_s3),
    .bm_s1(bm_s1), .bm_s2(bm_s2), .bm_s3(bm_s3),
    .bm_lambda1(bm_lambda1), .bm_lambda2(bm_lambda2),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_lambda1(rsp_lambda1), .rsp_lambda2(rsp_lambda2),
    .rsp_nerr(rsp_nerr), .rsp_fail(rsp_fail), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- GF(16) helpers, x^4+x+1 ----------------
  function automatic logic [3:0] gf_mul(logic [3:0] a, logic [3:0] b);
    logic [3:0] p = 4'd0;
    logic [3:0] x = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ x;
      x = x[3] ? ({x[2:0], 1'b0} ^ 4'h3) : {x[2:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [3:0] gf_inv(logic [3:0] a);
    logic [3:0] r = 4'd0;
    for (int i = 1; i < 16; i++)
      if (gf_mul(a, 4'(i)) == 4'd1) r = 4'(i);
    return r;
  endfunction

  // t=2 BCH locator: lambda1 = S1, lambda2 = (S3 + S1^3) / S1.
  function automatic logic [7:0] bm_model(logic [3:0] s1, logic [3:0] s3);
    logic [3:0] l2;
    if (s1 == 4'd0) return 8'h00;
    l2 = gf_mul(s3 ^ gf_mul(s1, gf_mul(s1, s1)), gf_inv(s1));
    return {s1, l2};
  endfunction

  // Expected response packed as {id, lambda1, lambda2, nerr, fail}.
  function automatic logic [11:0] exp_rsp(logic id, logic [11:0] s);
    logic [7:0] lam;
    logic [1:0] n;
    if (s == 12'd0) return {id, 11'd0};
    lam = bm_model(s[11:8], s[3:0]);
    n = (lam[3:0] != 4'd0) ? 2'd2 : ((lam[7:4] != 4'd0) ? 2'd1 : 2'd0);
    return {id, lam, n, (lam == 8'd0)};
  endfunction

  always_comb begin
    {bm_lambda1, bm_lambda2} = bm_model(bm_s1, bm_s3);
  end

  // ---------------- scoreboard state ----------------
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic [11:0] exp_q[$];
  bit          m_busy = 1'b0;
  bit          m_last = 1'b1;
  int          m_due = 0;
  logic [11:0] m_bm = 12'd0;
  bit          acc0 = 1'b0, acc1 = 1'b0, prev_valid = 1'b0;
  int          last_acc_cyc = 0, last_hs_cyc = 0, last_lat = 0;
  bit          last_acc_id = 1'b0;
  int          acc_log[$];
  int          id_log[$];

  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // ---------------- compare process (negedge) ----------------
  initial begin
    bit          exp_valid, exp_r0, exp_r1;
    logic [11:0] sel;
    forever begin
      @(negedge clk);
      cyc++;
      acc0 = 1'b0;
      acc1 = 1'b0;
      if (!rst) begin
        chk("reset_outs", int'({req0_ready, req1_ready, rsp_valid, busy, rsp_id, rsp_fail,
                                rsp_nerr, dbg_state}), 0);
        chk("reset_data", int'({bm_s1, bm_s2, bm_s3, rsp_lambda1, rsp_lambda2}), 0);
        m_busy = 1'b0; m_last = 1'b1; m_bm = 12'd0; prev_valid = 1'b0;
        exp_q.delete();
      end else begin
        exp_valid = m_busy && (cyc >= m_due);
        exp_r0 = 1'b0;
        exp_r1 = 1'b0;
        if (!m_busy) begin
          if (req0_valid && req1_valid) begin
            if (m_last) exp_r0 = 1'b1;
            else exp_r1 = 1'b1;
          end else begin
            exp_r0 = req0_valid;
            exp_r1 = req1_valid;
          end
        end
        chk("rsp_valid", int'(rsp_valid), int'(exp_valid));
        chk("busy", int'(busy), int'(m_busy));
        chk("ready", int'({req0_ready, req1_ready}), int'({exp_r0, exp_r1}));
        chk("bm_s", int'({bm_s1, bm_s2, bm_s3}), int'(m_bm));
        if (exp_valid) begin
          if (exp_q.size() == 0) chk("rsp_queue", exp_q.size(), 1);
          else chk("rsp_data", int'({rsp_id, rsp_lambda1, rsp_lambda2, rsp_nerr, rsp_fail}),
                   int'(exp_q[0]));
        end
        if (rsp_valid && !prev_valid) last_lat = cyc - last_acc_cyc;
        prev_valid = rsp_valid;
        if (exp_valid && rsp_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          m_busy = 1'b0;
          last_hs_cyc = cyc;
        end else if (exp_r0 || exp_r1) begin
          sel = exp_r1 ? {req1_s1, req1_s2, req1_s3} : {req0_s1, req0_s2, req0_s3};
          exp_q.push_back(exp_rsp(exp_r1, sel));
          m_last = exp_r1;
          m_busy = 1'b1;
          m_due = cyc + ((sel == 12'd0) ? 2 : BM_LAT + 1);
          if (sel != 12'd0) m_bm = sel;
          acc0 = exp_r0;
          acc1 = exp_r1;
          last_acc_cyc = cyc;
          last_acc_id = exp_r1;
          acc_log.push_back(cyc);
          id_log.push_back(int'(exp_r1));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input bit id, input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] s3);
    bit got = 1'b0;
    if (id) begin req1_valid = 1'b1; {req1_s1, req1_s2, req1_s3} = {s1, s2, s3}; end
    else begin req0_valid = 1'b1; {req0_s1, req0_s2, req0_s3} = {s1, s2, s3}; end
    for (int k = 0; k < 60 && !got; k++) begin
      tick();
      got = id ? acc1 : acc0;
    end
    chk("send_accepted", int'(got), 1);
    if (id) req1_valid = 1'b0;
    else req0_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    bit seen = 1'b0;
    for (int k = 0; k < 60 && !seen; k++) begin
      if (rsp_valid) seen = 1'b1;
      else tick();
    end
    chk("rsp_arrived", int'(seen), 1);
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 60 && busy; k++) tick();
    chk("drain_idle", int'(busy), 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    {req0_s1, req0_s2, req0_s3} = 12'd0;
    {req1_s1, req1_s2, req1_s3} = 12'd0;
    do_reset();
    chk("post_reset_busy", int'(busy), 0);
    chk("post_reset_bm", int'({bm_s1, bm_s2, bm_s3}), 0);

    // BM path, two-error syndromes
    send(1'b0, 4'd3, 4'd5, 4'd6);
    wait_rsp();
    chk("t1_latency", last_lat, 5);
    chk("t1_id", int'(rsp_id), 0);
    chk("t1_lambda1", int'(rsp_lambda1), 3);
    chk("t1_lambda2", int'(rsp_lambda2), 7);
    chk("t1_nerr", int'(rsp_nerr), 2);
    chk("t1_fail", int'(rsp_fail), 0);
    chk("t1_bm_s", int'({bm_s1, bm_s2, bm_s3}), 'h356);
    drain();

    // single error from requester 1
    send(1'b1, 4'd1, 4'd1, 4'd1);
    wait_rsp();
    chk("t2_id", int'(rsp_id), 1);
    chk("t2_lambdas", int'({rsp_lambda1, rsp_lambda2}), 'h10);
    chk("t2_nerr_fail", int'({rsp_nerr, rsp_fail}), 'b010);
    drain();

    // zero-syndrome bypass
    send(1'b0, 4'd0, 4'd0, 4'd0);
    wait_rsp();
    chk("byp_latency", last_lat, 2);
    chk("byp_result", int'({rsp_lambda1, rsp_lambda2, rsp_nerr, rsp_fail}), 0);
    chk("byp_bm_kept", int'({bm_s1, bm_s2, bm_s3}), 'h111);
    drain();

    // contention from reset
    {req0_s1, req0_s2, req0_s3} = 12'h356;
    {req1_s1, req1_s2, req1_s3} = 12'h111;
    req0_valid = 1'b1; req1_valid = 1'b1;
    rst = 1'b0;
    repeat (2) tick();
    acc_log.delete(); id_log.delete();
    rst = 1'b1;
    for (int k = 0; k < 80 && acc_log.size() < 4; k++) tick();
    chk("cont_count", acc_log.size() >= 4 ? 4 : acc_log.size(), 4);
    if (acc_log.size() >= 4) begin
      for (int i = 0; i < 4; i++) chk("cont_grant", id_log[i], i % 2);
      for (int i = 0; i < 3; i++) chk("cont_spacing", acc_log[i+1] - acc_log[i], BM_LAT + 2);
    end
    drain();

    // backpressure with a waiting requester
    rsp_ready = 1'b0;
    send(1'b0, 4'd3, 4'd5, 4'd6);
    {req1_s1, req1_s2, req1_s3} = 12'h111;
    req1_valid = 1'b1;
    wait_rsp();
    chk("bp_latency", last_lat, 5);
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("bp_hold_ready", int'({req0_ready, req1_ready}), 0);
      chk("bp_hold_lambda", int'({rsp_valid, rsp_lambda1, rsp_lambda2}), 'h137);
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 20 && !acc1; k++) tick();
    chk("bp_next_accept", last_acc_cyc - last_hs_cyc, 1);
    drain();

    // reset in the middle of a RUN job
    send(1'b0, 4'd3, 4'd5, 4'd6);
    tick();
    rst = 1'b0;
    #1;
    chk("midrun_reset_outs", int'({busy, rsp_valid, req0_ready, req1_ready}), 0);
    chk("midrun_reset_bm", int'({bm_s1, bm_s2, bm_s3}), 0);
    {req0_s1, req0_s2, req0_s3} = 12'h111;
    {req1_s1, req1_s2, req1_s3} = 12'h356;
    req0_valid = 1'b1; req1_valid = 1'b1;
    repeat (3) tick();
    acc_log.delete(); id_log.delete();
    rst = 1'b1;
    for (int k = 0; k < 10 && acc_log.size() == 0; k++) tick();
    chk("midrun_first_tie", acc_log.size() > 0 ? id_log[0] : -1, 0);
    drain();

    // random traffic
    for (int k = 0; k < 2000; k++) begin
      if (!req0_valid || acc0) begin
        req0_valid = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 4) == 0) {req0_s1, req0_s2, req0_s3} = 12'd0;
        else {req0_s1, req0_s2, req0_s3} = 12'($urandom_range(0, 4095));
      end
      if (!req1_valid || acc1) begin
        req1_valid = ($urandom_range(0, 2) != 0);
        if ($urandom_range(0, 4) == 0) {req1_s1, req1_s2, req1_s3} = 12'd0;
        else {req1_s1, req1_s2, req1_s3} = 12'($urandom_range(0, 4095));
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    repeat (2) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bch_bm_arb.md
# bch_bm_arb

Round-robin arbiter and sequencer that shares one `bch_bm_block_p` Berlekamp-Massey instance between two syndrome producers in the GF(2^4) BCH(15,7), t=2 decoder.
- Each request carries S1/S2/S3.
- The block grants one requester, drives the syndromes onto the BM inputs, holds them stable for `BM_LAT` cycles, and captures `lambda1`/`lambda2`.
- It returns the result with requester ID and error-count classification over a valid/ready response port.
- All-zero syndromes bypass the BM block.

## Interface
- `BM_LAT`, 4, cycles the syndromes are held on the BM inputs before lambda capture; legal range 1..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req0_valid` in 1: requester 0 has syndromes.
- `req0_ready` out 1: requester 0 accepted this cycle.
- `req0_s1`, `req0_s2`, `req0_s3` in 4 each: requester 0 syndromes.
- `req1_valid` in 1; `req1_ready` out 1; `req1_s1`, `req1_s2`, `req1_s3` in 4 each: same as requester 0, for requester 1.
- `bm_s1`, `bm_s2`, `bm_s3` out 4 each: to the BM block.
- `bm_lambda1`, `bm_lambda2` in 4 each: from the BM block.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out 1: requester that owns the response.
- `rsp_lambda1`, `rsp_lambda2` out 4 each: error-locator coefficients.
- `rsp_nerr` out 2: 0, 1 or 2 errors.
- `rsp_fail` out 1: uncorrectable (syndromes nonzero, lambdas both zero).
- `busy` out 1: state is not IDLE.

## Operation
- FSM states: IDLE, RUN, BYP, RESP.
  - IDLE → RUN on accept with nonzero syndromes.
  - IDLE → BYP on accept with S1=S2=S3=0.
  - RUN → RESP after `BM_LAT` RUN cycles.
  - BYP → RESP after 1 cycle.
  - RESP → IDLE when `rsp_ready`=1.
- Arbitration, IDLE only:
  - Grant the sole valid requester.
  - If both are valid, grant the one not granted last.
  - `last_grant` resets to 1, so req0 wins the first tie.
  - `reqN_ready` is combinational: (state==IDLE) & grantN. At most one ready is high per cycle, and ready is never high outside IDLE.
- On accept: latch syndromes into `bm_s*` and latch the ID. `bm_s*` changes only at an accept edge.
- RUN:
  - A 4-bit counter loads 1 on entering RUN and increments each RUN cycle.
  - On the cycle the counter equals `BM_LAT`, `bm_lambda1`/`bm_lambda2` are registered into `rsp_lambda*` and the FSM moves to RESP.
- BYP: `rsp_lambda1`=`rsp_lambda2`=0, `rsp_nerr`=0, `rsp_fail`=0. The BM inputs are not updated, so `bm_s*` keeps its previous value.
- Classification, registered with the lambdas:
  - `nerr`=2 if lambda2≠0.
  - Else `nerr`=1 if lambda1≠0.
  - Else `nerr`=0.
  - `fail`=1 iff the latched syndromes are nonzero and both lambdas are 0.
- RESP: `rsp_*` is stable while `rsp_valid`=1 and `rsp_ready`=0. Arbitration is frozen, and requests arriving meanwhile wait.
- Reset, asynchronous and any state: FSM→IDLE, counter=0, `last_grant`=1. All outputs go to 0: `bm_s*`, `rsp_*`, `busy`, and both readies. An in-flight job is discarded with no response.

## Timing
- Accept edge = cycle 0. RUN occupies cycles 1..`BM_LAT`. `rsp_valid` rises at cycle `BM_LAT`+1 (5 with the default).
- Bypass: `rsp_valid` rises at cycle 2.
- Response handshake at cycle R (`rsp_valid`&`rsp_ready`) → IDLE at R+1 → the next accept can occur at R+1.
- Minimum job period is `BM_LAT`+2 cycles.
- `busy` is high from cycle 1 through the handshake cycle.
- `bm_s*` is stable from cycle 1 through capture, as the BM block requires.
- The response is dropped only by reset; `rsp_valid` never deasserts without a handshake.

## Test plan
- **Single request through the BM path:**
  - Stimulus: req0 S=(3,5,6), instantiated with the real `bch_bm_block_p`, `rsp_ready`=1.
  - Response: accept at cycle 0; `bm_s*`=(3,5,6) from cycle 1; `rsp_valid` at cycle 5.
  - Result: `rsp_id`=0, lambda1=3, lambda2=7, nerr=2, fail=0.
- **Single-error case:**
  - Stimulus: req1 S=(1,1,1).
  - Response: `rsp_id`=1, lambda1=1, lambda2=0, nerr=1, fail=0.
- **Zero-syndrome bypass:**
  - Stimulus: req0 S=(0,0,0).
  - Response: `rsp_valid` at cycle 2 with lambdas 0 and nerr=0.
  - `bm_s*` is unchanged from the previous job.
- **Contention:**
  - Stimulus: both requesters valid continuously from reset, `rsp_ready`=1.
  - Response: grants alternate 0,1,0,1; accepts are spaced `BM_LAT`+2 cycles apart; `reqN_ready` is never high simultaneously.
- **Backpressure:**
  - Stimulus: `rsp_ready`=0 for 10 cycles after `rsp_valid`.
  - Response: all `rsp_*` hold stable and `reqN_ready` stays 0; the handshake completes the cycle `rsp_ready` rises, and the next accept follows one cycle later.
- **Reset mid-RUN:**
  - Stimulus: assert `rst` low at cycle 2 of a job.
  - Response: all outputs are 0 immediately, no response is produced, and after release the first tie grants req0.
